uart_tx_core: RTL

UART_TX_CORE -- requirements
Module: uart_tx_core

---
 rtl/uart_tx_core_if.sv | 21 ++
 rtl/uart_tx_core.sv | 118 +++++++++++
 2 files changed

// File: rtl/uart_tx_core_if.sv
// Byte-in / serial-out bundle for uart_tx_core: valid/ready byte handshake plus line and status outputs.
interface uart_tx_core_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_i;
    logic                 valid_i;
    logic                 ready_o;
    logic                 tx_o;
    logic                 busy_o;
    logic                 done_o;

    modport master (
        output data_i, valid_i,
        input  ready_o, tx_o, busy_o, done_o
    );

    modport slave (
        input  data_i, valid_i,
        output ready_o, tx_o, busy_o, done_o
    );
endinterface

// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1-2 stop bits.
// The serial line is registered; done_o marks the first idle cycle after each frame.
module uart_tx_core #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    uart_tx_core_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic          PAR_ON    = (PARITY_EN != 0);
    localparam logic          ODD       = (PARITY_ODD != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        baud_q, baud_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 bit_end;

    assign bit_end = (baud_q == BAUD_LAST);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        par_d   = par_q;
        unique case (state_q)
            IDLE: begin
                if (bus.valid_i) begin
                    state_d = START;
                    sh_d    = bus.data_i;
                    par_d   = (^bus.data_i) ^ ODD;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == DATA_LAST) begin
                        state_d = PAR_ON ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        sh_d  = sh_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) state_d = IDLE;
                    else                    bit_d   = bit_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Both counters restart on every state change so each state begins on a bit boundary.
        if (state_d != state_q) begin
            baud_d = '0;
            bit_d  = '0;
        end else if (state_q != IDLE) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end
    end

    // The line level is derived from the next state so tx_q changes on the same edge as state_q.
    always_comb begin
        tx_d   = 1'b1;
        done_d = (state_q == STOP) && (state_d == IDLE);
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = sh_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    assign bus.ready_o = (state_q == IDLE);
    assign bus.busy_o  = (state_q != IDLE);
    assign bus.tx_o    = tx_q;
    assign bus.done_o  = done_q;
endmodule
